// File: rtl/led_ctrl_pkg.sv
// Shared types and register addresses for the LED controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeOn    = 2'd1,
        ModeBlink = 2'd2,
        ModePwm   = 2'd3
    } mode_e;

    localparam logic [4:0] AddrPrescale    = 5'd0;
    localparam logic [4:0] AddrBlinkPeriod = 5'd1;
    localparam logic [4:0] AddrInfo        = 5'd2;
    localparam logic [4:0] AddrChanBase    = 5'd3;

    // Word address of channel idx's configuration register.
    function automatic logic [4:0] chan_addr(input int unsigned idx);
        return AddrChanBase + 5'(idx);
    endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Register bus between a host and the LED controller.
interface led_ctrl_if;

    logic [4:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;

    modport master (
        output bus_addr, bus_write_data, bus_write_enable, bus_read_enable,
        input  bus_read_data, bus_read_data_valid
    );

    modport slave (
        input  bus_addr, bus_write_data, bus_write_enable, bus_read_enable,
        output bus_read_data, bus_read_data_valid
    );

endinterface

// File: rtl/led_channel.sv
// One LED channel: decodes MODE/DUTY against the shared counters and
// registers the polarity-corrected drive.
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int unsigned PWM_WIDTH  = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  mode_e                mode_i,
    input  logic [PWM_WIDTH-1:0] duty_i,
    input  logic [PWM_WIDTH-1:0] pwm_counter_i,
    input  logic                 blink_phase_i,
    output logic                 led_o
);

    logic on_state;
    logic led_q;

    // On-state decode from the channel mode.
    always_comb begin
        on_state = 1'b0;
        unique case (mode_i)
            ModeOff:   on_state = 1'b0;
            ModeOn:    on_state = 1'b1;
            ModeBlink: on_state = blink_phase_i;
            ModePwm:   on_state = (pwm_counter_i < duty_i);
            default:   on_state = 1'b0;
        endcase
    end

    // Output register; reset shows the LED dark for either polarity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= ACTIVE_LOW;
        end else begin
            led_q <= on_state ^ ACTIVE_LOW;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// LED controller: register file, shared prescale/PWM/blink counters and
// NUM_LEDS output channels.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 3,
    parameter int unsigned PWM_WIDTH      = 8,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    led_ctrl_if.slave           bus,
    output logic [NUM_LEDS-1:0] leds
);

    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [15:0]               blink_period_q, blink_period_d;
    mode_e                     mode_q [NUM_LEDS];
    mode_e                     mode_d [NUM_LEDS];
    logic [PWM_WIDTH-1:0]      duty_q [NUM_LEDS];
    logic [PWM_WIDTH-1:0]      duty_d [NUM_LEDS];

    logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_WIDTH-1:0]      pwm_q, pwm_d;
    logic [15:0]               blink_cnt_q, blink_cnt_d;
    logic                      blink_phase_q, blink_phase_d;
    logic                      tick, wrap;

    logic [31:0]               rdata_mux;
    logic [31:0]               rdata_q;
    logic                      rvalid_q;

    // Upper write-data bits beyond each register's width are dropped.
    logic unused_wdata;
    assign unused_wdata = ^bus.bus_write_data;

    // Register writes; INFO and unmapped addresses fall through untouched.
    always_comb begin
        prescale_d     = prescale_q;
        blink_period_d = blink_period_q;
        mode_d         = mode_q;
        duty_d         = duty_q;
        if (bus.bus_write_enable) begin
            if (bus.bus_addr == AddrPrescale) begin
                prescale_d = bus.bus_write_data[PRESCALE_WIDTH-1:0];
            end
            if (bus.bus_addr == AddrBlinkPeriod) begin
                blink_period_d = bus.bus_write_data[15:0];
            end
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (bus.bus_addr == chan_addr(i)) begin
                    mode_d[i] = mode_e'(bus.bus_write_data[1:0]);
                    duty_d[i] = bus.bus_write_data[PWM_WIDTH+1:2];
                end
            end
        end
    end

    // Shared timebase: prescaler -> PWM counter -> blink counter.
    always_comb begin
        tick          = (pre_cnt_q == prescale_q);
        wrap          = tick && (pwm_q == '1);
        pre_cnt_d     = tick ? '0 : pre_cnt_q + PRESCALE_WIDTH'(1);
        pwm_d         = tick ? pwm_q + PWM_WIDTH'(1) : pwm_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (bus.bus_write_enable && bus.bus_addr == AddrPrescale) begin
            pre_cnt_d = '0;
        end
        if (wrap) begin
            // >= so a shrunk period takes effect at the next wrap.
            if (blink_cnt_q >= blink_period_q) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    // Read mux; reads see the pre-write register contents.
    always_comb begin
        rdata_mux = '0;
        unique case (bus.bus_addr)
            AddrPrescale:    rdata_mux = 32'(prescale_q);
            AddrBlinkPeriod: rdata_mux = 32'(blink_period_q);
            AddrInfo:        rdata_mux = {16'(PWM_WIDTH), 16'(NUM_LEDS)};
            default:         rdata_mux = '0;
        endcase
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (bus.bus_addr == chan_addr(i)) begin
                rdata_mux = 32'({duty_q[i], mode_q[i]});
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q     <= '0;
            blink_period_q <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= ModeOff;
                duty_q[i] <= '0;
            end
            pre_cnt_q      <= '0;
            pwm_q          <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            blink_period_q <= blink_period_d;
            mode_q         <= mode_d;
            duty_q         <= duty_d;
            pre_cnt_q      <= pre_cnt_d;
            pwm_q          <= pwm_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            rdata_q        <= bus.bus_read_enable ? rdata_mux : '0;
            rvalid_q       <= bus.bus_read_enable;
        end
    end

    assign bus.bus_read_data       = rdata_q;
    assign bus.bus_read_data_valid = rvalid_q;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_channel #(
            .PWM_WIDTH  (PWM_WIDTH),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .mode_i        (mode_q[g]),
            .duty_i        (duty_q[g]),
            .pwm_counter_i (pwm_q),
            .blink_phase_i (blink_phase_q),
            .led_o         (leds[g])
        );
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with a read-data scoreboard.
module tb_led_ctrl;
    import led_ctrl_pkg::*;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] leds;

    led_ctrl_if bus ();

    led_ctrl #(
        .NUM_LEDS       (3),
        .PWM_WIDTH      (8),
        .PRESCALE_WIDTH (16),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q  [$];
    string       name_q [$];
    logic [31:0] mon_exp;
    string       mon_name;

    // Scoreboard: every valid beat must match the oldest expected read.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.bus_read_data_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: data=%h, no read outstanding",
                             bus.bus_read_data);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_name = name_q.pop_front();
                    if (bus.bus_read_data !== mon_exp) begin
                        bad++;
                        $display("FAIL %s: got %h want %h", mon_name, bus.bus_read_data, mon_exp);
                    end
                end
            end else begin
                total++;
                if (bus.bus_read_data !== 32'h0) begin
                    bad++;
                    $display("FAIL idle_rdata: got %h want 0", bus.bus_read_data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.bus_addr         = a;
        bus.bus_write_data   = d;
        bus.bus_write_enable = 1'b1;
        @(negedge clk);
        bus.bus_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        bus.bus_addr        = a;
        bus.bus_read_enable = 1'b1;
        @(negedge clk);
        bus.bus_read_enable = 1'b0;
        total++;
        if (bus.bus_read_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_latency: valid=%b want 1", n, bus.bus_read_data_valid);
        end
    endtask

    task automatic test_reset;
        bus.bus_addr         = '0;
        bus.bus_write_data   = '0;
        bus.bus_write_enable = 1'b0;
        bus.bus_read_enable  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (leds !== 3'b111) begin
            bad++;
            $display("FAIL reset_leds: got %b want 111", leds);
        end
        total++;
        if (bus.bus_read_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", bus.bus_read_data_valid);
        end
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(AddrInfo, 32'h0008_0003, "info");
        bus_read(AddrPrescale, 32'h0, "prescale_rst");
        bus_read(AddrBlinkPeriod, 32'h0, "blink_rst");
        bus_read(5'd3, 32'h0, "chan0_rst");
    endtask

    task automatic test_latency;
        bus_write(5'd5, 32'h1);
        total++;
        if (leds[2] !== 1'b1) begin
            bad++;
            $display("FAIL led2_one_edge: got %b want 1", leds[2]);
        end
        @(negedge clk);
        total++;
        if (leds[2] !== 1'b0) begin
            bad++;
            $display("FAIL led2_two_edges: got %b want 0", leds[2]);
        end
    endtask

    task automatic test_pwm;
        int lit;
        int run;
        int gap;
        int wait_cnt;
        logic prev;
        bus_write(AddrPrescale, 32'h0);
        bus_write(5'd3, (32'd64 << 2) | 32'd3);
        repeat (4) @(negedge clk);
        lit = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (leds[0] === 1'b0) lit++;
        end
        total++;
        if (lit != 128) begin
            bad++;
            $display("FAIL pwm_lit_count: got %0d want 128", lit);
        end
        total++;
        if (leds[1] !== 1'b1) begin
            bad++;
            $display("FAIL led1_off: got %b want 1", leds[1]);
        end
        wait_cnt = 0;
        prev     = leds[0];
        @(negedge clk);
        while (!(prev === 1'b1 && leds[0] === 1'b0) && wait_cnt < 300) begin
            prev = leds[0];
            @(negedge clk);
            wait_cnt++;
        end
        run = 0;
        while (leds[0] === 1'b0 && run < 300) begin
            run++;
            @(negedge clk);
        end
        gap = 0;
        while (leds[0] === 1'b1 && gap < 300) begin
            gap++;
            @(negedge clk);
        end
        total++;
        if (run != 64) begin
            bad++;
            $display("FAIL pwm_on_run: got %0d want 64", run);
        end
        total++;
        if (run + gap != 256) begin
            bad++;
            $display("FAIL pwm_period: got %0d want 256", run + gap);
        end
    endtask

    task automatic test_blink;
        int   n;
        logic cur;
        bus_write(AddrPrescale, 32'h1);
        bus_write(AddrBlinkPeriod, 32'h0);
        bus_write(5'd4, 32'h2);
        cur = leds[1];
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (leds[1] === cur && n < 1200);
        total++;
        if (n >= 1200) begin
            bad++;
            $display("FAIL blink_first_toggle: no toggle within %0d cycles, want <= 1024", n);
        end
        for (int k = 0; k < 2; k++) begin
            cur = leds[1];
            n   = 0;
            do begin
                @(negedge clk);
                n++;
            end while (leds[1] === cur && n < 1200);
            total++;
            if (n != 512) begin
                bad++;
                $display("FAIL blink_interval%0d: got %0d want 512", k, n);
            end
        end
    endtask

    task automatic test_collision;
        bus_write(5'd5, 32'h1);
        exp_q.push_back(32'h1);
        name_q.push_back("collide_old");
        bus.bus_addr         = 5'd5;
        bus.bus_write_data   = 32'h2;
        bus.bus_write_enable = 1'b1;
        bus.bus_read_enable  = 1'b1;
        @(negedge clk);
        bus.bus_write_enable = 1'b0;
        bus.bus_read_enable  = 1'b0;
        total++;
        if (bus.bus_read_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL collide_latency: valid=%b want 1", bus.bus_read_data_valid);
        end
        bus_read(5'd5, 32'h2, "collide_new");
    endtask

    task automatic test_back_to_back;
        bus_write(5'd31, 32'hFFFF_FFFF);
        bus_write(AddrInfo, 32'h1234_5678);
        bus_write(5'd6, 32'hFFFF_FFFF);
        bus_read(5'd31, 32'h0, "unmapped31");
        bus_read(AddrInfo, 32'h0008_0003, "info_after_write");
        bus_read(5'd6, 32'h0, "unmapped6");
        bus_read(AddrPrescale, 32'h1, "prescale_kept");
        bus_read(AddrBlinkPeriod, 32'h0, "blink_kept");
        bus_read(5'd3, 32'h103, "chan0_kept");
        bus_read(5'd4, 32'h2, "chan1_kept");
        bus_read(5'd5, 32'h2, "chan2_kept");
        bus_write(AddrPrescale, 32'hABCD_0001);
        bus_read(AddrPrescale, 32'h1, "prescale_hi_bits");
        bus_write(AddrBlinkPeriod, 32'h5A5A_0007);
        bus_read(AddrBlinkPeriod, 32'h7, "blink_hi_bits");
        bus_write(5'd3, 32'hFFFF_FC07);
        bus_read(5'd3, 32'h3FF & 32'hFFFF_FC07, "chan0_hi_bits");
    endtask

    task automatic test_reset_mid_read;
        int n;
        bus_write(AddrPrescale, 32'h0);
        bus_write(5'd3, (32'd64 << 2) | 32'd3);
        bus_write(5'd4, 32'h1);
        n = 0;
        while (leds[0] !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (leds[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL pre_reset_lit: got %b want 00", leds[1:0]);
        end
        bus.bus_addr        = AddrInfo;
        bus.bus_read_enable = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (leds !== 3'b111) begin
            bad++;
            $display("FAIL async_reset_leds: got %b want 111", leds);
        end
        @(negedge clk);
        bus.bus_read_enable = 1'b0;
        total++;
        if (bus.bus_read_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_read_dropped: valid=%b want 0", bus.bus_read_data_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_after_reset: got %0d want 0", exp_q.size());
        end
        bus_read(5'd3, 32'h0, "chan0_cleared");
        bus_read(AddrPrescale, 32'h0, "prescale_cleared");
        total++;
        if (leds !== 3'b111) begin
            bad++;
            $display("FAIL leds_after_reset: got %b want 111", leds);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pwm();
        test_blink();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reads_outstanding: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
